// File: rtl/ddr5_dram_cmd_responder.sv
// ddr5_dram_cmd_responder: DRAM-side checker and data-window driver for the DDR5 scheduler command stream
// Ports: clock/reset_n (async active-low); cmd_* command input (valid, code, bg, ba, row, col);
// rd_data_valid/rd_beat/rd_col read burst window; wr_data_ready write burst window;
// err_valid/err_code/err_bg/err_ba one-cycle rejection report; busy activity flag.
// Optional macro DDR5_RESP_STATS_EN adds 32-bit stat_act/stat_rd/stat_wr/stat_pre/stat_err counters.
module ddr5_dram_cmd_responder #(
  parameter int NUM_BG = 8,
  parameter int NUM_BA = 4,
  parameter int ROW_W = 16,
  parameter int COL_W = 11,
  parameter int T_RCD = 39,
  parameter int T_RAS = 76,
  parameter int T_RP = 39,
  parameter int T_CL = 40,
  parameter int T_CWD = 38,
  parameter int T_RTP = 18,
  parameter int T_WR = 72,
  parameter int T_BURST = 8,
  parameter int T_RFC = 295
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_code,
  input  logic [2:0]       cmd_bg,
  input  logic [1:0]       cmd_ba,
  input  logic [ROW_W-1:0] cmd_row,
  input  logic [COL_W-1:0] cmd_col,
  output logic             rd_data_valid,
  output logic [2:0]       rd_beat,
  output logic [COL_W-1:0] rd_col,
  output logic             wr_data_ready,
  output logic             err_valid,
  output logic [3:0]       err_code,
  output logic [2:0]       err_bg,
  output logic [1:0]       err_ba,
  output logic             busy
`ifdef DDR5_RESP_STATS_EN
  ,
  output logic [31:0]      stat_act,
  output logic [31:0]      stat_rd,
  output logic [31:0]      stat_wr,
  output logic [31:0]      stat_pre,
  output logic [31:0]      stat_err
`endif
);
  localparam int NB = NUM_BG * NUM_BA;
  localparam int BW = $clog2(NB);
  localparam int CW = 16;
  localparam int NS = 4;
  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4, C_REF = 3'd5;
  typedef enum logic [1:0] {IDLE, ACTIVE, PRECH} bank_t;
  bank_t st [NB];
  bank_t st_n [NB];
  logic [NB-1:0][ROW_W-1:0] open_row;
  // Counters hold the number of cycles still to wait, so a gate opens exactly when its counter is 0.
  logic [CW-1:0] rcd [NB], ras [NB], rp [NB], rtp [NB], wr [NB];
  logic [CW-1:0] rfc;
  // Slot rem counts down to the end of its burst; the burst is on the bus while rem is 1..T_BURST.
  logic [CW-1:0] s_rem [NS];
  logic s_wr [NS];
  logic [COL_W-1:0] s_col [NS];
  logic [BW-1:0] s_bank [NS];
  logic [BW-1:0] bi;
  logic [CW-1:0] dly;
  logic [1:0] fs;
  logic [3:0] ecode;
  logic is_cmd, is_act, is_rd, is_wr, is_pre, is_ref, burst, clash, full, any_open, ok;
  logic unused_row;
  assign bi = BW'(int'(cmd_bg) * NUM_BA + int'(cmd_ba));
  assign is_cmd = cmd_valid && cmd_code != C_NOP;
  assign is_act = cmd_valid && cmd_code == C_ACT;
  assign is_rd = cmd_valid && cmd_code == C_RD;
  assign is_wr = cmd_valid && cmd_code == C_WR;
  assign is_pre = cmd_valid && cmd_code == C_PRE;
  assign is_ref = cmd_valid && cmd_code == C_REF;
  assign burst = is_rd || is_wr;
  assign dly = CW'(is_rd ? T_CL : T_CWD);
  assign ok = is_cmd && ecode == 4'd0;
  // Open rows are kept for visibility only; nothing in this model consumes them.
  assign unused_row = ^open_row;
  // A new window starting dly cycles out overlaps a slot whose rem lies in (dly, dly+2*T_BURST).
  always_comb begin
    clash = 1'b0;
    full = 1'b1;
    fs = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      clash = clash || (s_rem[i] > dly && s_rem[i] < dly + CW'(2 * T_BURST));
      if (s_rem[i] == '0) begin
        full = 1'b0;
        fs = 2'(i);
      end
    end
  end
  always_comb begin
    any_open = 1'b0;
    for (int b = 0; b < NB; b++) any_open = any_open || st[b] != IDLE;
  end
  // ACT to a still-precharging bank reports tRP rather than an illegal-state error.
  always_comb begin
    ecode = 4'd0;
    if (is_cmd) begin
      if (rfc != '0) ecode = 4'd9;
      else if (cmd_code > C_REF || (is_act && st[bi] == ACTIVE) || (burst && st[bi] != ACTIVE) ||
               (is_pre && st[bi] == IDLE) || (is_ref && any_open)) ecode = 4'd1;
      else if (is_act && rp[bi] != '0) ecode = 4'd4;
      else if (burst && rcd[bi] != '0) ecode = 4'd2;
      else if (is_pre && st[bi] == ACTIVE && ras[bi] != '0) ecode = 4'd3;
      else if (is_pre && st[bi] == ACTIVE && rtp[bi] != '0) ecode = 4'd5;
      else if (is_pre && st[bi] == ACTIVE && wr[bi] != '0) ecode = 4'd6;
      else if (burst && (clash || full)) ecode = 4'd7;
    end
  end
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      st_n[b] = st[b];
      if (st[b] == PRECH && rp[b] == '0) st_n[b] = IDLE;
      if (ok && bi == BW'(b) && is_act) st_n[b] = ACTIVE;
      else if (ok && bi == BW'(b) && is_pre && st[b] == ACTIVE) st_n[b] = PRECH;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) for (int b = 0; b < NB; b++) st[b] <= IDLE;
    else for (int b = 0; b < NB; b++) st[b] <= st_n[b];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rfc <= '0;
      open_row <= '0;
      for (int b = 0; b < NB; b++) begin
        rcd[b] <= '0;
        ras[b] <= '0;
        rp[b] <= '0;
        rtp[b] <= '0;
        wr[b] <= '0;
      end
      for (int s = 0; s < NS; s++) begin
        s_rem[s] <= '0;
        s_wr[s] <= 1'b0;
        s_col[s] <= '0;
        s_bank[s] <= '0;
      end
    end else begin
      rfc <= ok && is_ref ? CW'(T_RFC - 1) : rfc - CW'(rfc != '0);
      for (int b = 0; b < NB; b++) begin
        rcd[b] <= rcd[b] - CW'(rcd[b] != '0);
        ras[b] <= ras[b] - CW'(ras[b] != '0);
        rp[b] <= rp[b] - CW'(rp[b] != '0);
        rtp[b] <= rtp[b] - CW'(rtp[b] != '0);
        wr[b] <= wr[b] - CW'(wr[b] != '0);
      end
      if (ok && is_act) begin
        rcd[bi] <= CW'(T_RCD - 1);
        ras[bi] <= CW'(T_RAS - 1);
        open_row[bi] <= cmd_row;
      end
      if (ok && is_pre && st[bi] == ACTIVE) rp[bi] <= CW'(T_RP - 1);
      if (ok && is_rd) rtp[bi] <= CW'(T_RTP - 1);
      // Write recovery starts counting on the edge that closes the last write beat.
      for (int s = 0; s < NS; s++) begin
        s_rem[s] <= s_rem[s] - CW'(s_rem[s] != '0);
        if (s_rem[s] == CW'(1) && s_wr[s]) wr[s_bank[s]] <= CW'(T_WR);
      end
      if (ok && burst) begin
        s_rem[fs] <= dly + CW'(T_BURST - 1);
        s_wr[fs] <= is_wr;
        s_col[fs] <= cmd_col;
        s_bank[fs] <= bi;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_valid <= 1'b0;
      err_code <= '0;
      err_bg <= '0;
      err_ba <= '0;
    end else begin
      err_valid <= ecode != 4'd0;
      err_code <= ecode;
      err_bg <= ecode != 4'd0 ? cmd_bg : '0;
      err_ba <= ecode != 4'd0 ? cmd_ba : '0;
    end
  end
  always_comb begin
    rd_data_valid = 1'b0;
    rd_beat = '0;
    rd_col = '0;
    wr_data_ready = 1'b0;
    busy = any_open || rfc != '0;
    for (int s = 0; s < NS; s++) begin
      busy = busy || s_rem[s] != '0;
      if (s_rem[s] != '0 && s_rem[s] <= CW'(T_BURST)) begin
        if (s_wr[s]) wr_data_ready = 1'b1;
        else begin
          rd_data_valid = 1'b1;
          rd_beat = 3'(CW'(T_BURST) - s_rem[s]);
          rd_col = s_col[s];
        end
      end
    end
  end
`ifdef DDR5_RESP_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_act <= '0;
      stat_rd <= '0;
      stat_wr <= '0;
      stat_pre <= '0;
      stat_err <= '0;
    end else begin
      stat_act <= stat_act + 32'(ok && is_act);
      stat_rd <= stat_rd + 32'(ok && is_rd);
      stat_wr <= stat_wr + 32'(ok && is_wr);
      stat_pre <= stat_pre + 32'(ok && is_pre);
      stat_err <= stat_err + 32'(ecode != 4'd0);
    end
  end
`endif
endmodule

// File: tb/tb_ddr5_dram_cmd_responder.sv
// tb_ddr5_dram_cmd_responder: scoreboard bench for the DDR5 DRAM command responder
module tb_ddr5_dram_cmd_responder;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [2:0] cmd_code = '0;
  logic [2:0] cmd_bg = '0;
  logic [1:0] cmd_ba = '0;
  logic [15:0] cmd_row = '0;
  logic [10:0] cmd_col = '0;
  logic rd_data_valid, wr_data_ready, err_valid, busy;
  logic [2:0] rd_beat, err_bg;
  logic [10:0] rd_col;
  logic [3:0] err_code;
  logic [1:0] err_ba;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {int c; int beat; int col;} rd_t;
  typedef struct {int c; int code; int bg; int ba;} er_t;
  rd_t exp_rd[$];
  int exp_wr[$];
  er_t exp_err[$];
  rd_t mr;
  er_t me;
  int mw;

  ddr5_dram_cmd_responder dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .rd_data_valid(rd_data_valid), .rd_beat(rd_beat), .rd_col(rd_col),
    .wr_data_ready(wr_data_ready), .err_valid(err_valid), .err_code(err_code),
    .err_bg(err_bg), .err_ba(err_ba), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) if (reset_n) begin
    if (rd_data_valid) begin
      n_cmp++;
      if (exp_rd.size() == 0) begin
        n_bad++;
        $display("FAIL rd_burst: beat %0d col 0x%0h at cycle %0d, required no beat", rd_beat, rd_col, cyc);
      end else begin
        mr = exp_rd.pop_front();
        if (cyc !== mr.c || int'(rd_beat) !== mr.beat || int'(rd_col) !== mr.col) begin
          n_bad++;
          $display("FAIL rd_burst: cycle %0d beat %0d col 0x%0h, required cycle %0d beat %0d col 0x%0h",
                   cyc, rd_beat, rd_col, mr.c, mr.beat, mr.col);
        end
      end
    end
    if (wr_data_ready) begin
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_bad++;
        $display("FAIL wr_window: window at cycle %0d, required none", cyc);
      end else begin
        mw = exp_wr.pop_front();
        if (cyc !== mw) begin
          n_bad++;
          $display("FAIL wr_window: window at cycle %0d, required cycle %0d", cyc, mw);
        end
      end
    end
    if (err_valid) begin
      n_cmp++;
      if (exp_err.size() == 0) begin
        n_bad++;
        $display("FAIL err_report: code %0d bg %0d ba %0d at cycle %0d, required none", err_code, err_bg, err_ba, cyc);
      end else begin
        me = exp_err.pop_front();
        if (cyc !== me.c || int'(err_code) !== me.code || int'(err_bg) !== me.bg || int'(err_ba) !== me.ba) begin
          n_bad++;
          $display("FAIL err_report: cycle %0d code %0d bg %0d ba %0d, required cycle %0d code %0d bg %0d ba %0d",
                   cyc, err_code, err_bg, err_ba, me.c, me.code, me.bg, me.ba);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic issue(input int code, input int bg, input int ba, input int row, input int col);
    cmd_valid = 1'b1;
    cmd_code = 3'(code);
    cmd_bg = 3'(bg);
    cmd_ba = 2'(ba);
    cmd_row = 16'(row);
    cmd_col = 11'(col);
    tick();
    cmd_valid = 1'b0;
    cmd_code = '0;
  endtask

  task automatic push_rd(input int t, input int col);
    for (int i = 0; i < 8; i++) exp_rd.push_back('{t + i, i, col});
  endtask

  task automatic push_err(input int t, input int code, input int bg, input int ba);
    exp_err.push_back('{t, code, bg, ba});
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    cmd_code = '0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({rd_data_valid, wr_data_ready, err_valid, busy} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: rd/wr/err/busy %b, required 0000", {rd_data_valid, wr_data_ready, err_valid, busy});
    end
    n_cmp++;
    if ({rd_beat, rd_col, err_code, err_bg, err_ba} !== '0) begin
      n_bad++;
      $display("FAIL reset_fields: beat %0d col %0d code %0d bg %0d ba %0d, required all 0", rd_beat, rd_col, err_code, err_bg, err_ba);
    end
    reset_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({rd_data_valid, wr_data_ready, err_valid, busy} !== 4'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: rd/wr/err/busy %b, required 0000", {rd_data_valid, wr_data_ready, err_valid, busy});
    end
  endtask

  task automatic test_read();
    int b;
    do_reset();
    b = cyc;
    issue(1, 0, 0, 'h12, 0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_act: got %b required 1", busy);
    end
    wait_until(b + 39);
    push_rd(b + 79, 'h40);
    issue(2, 0, 0, 0, 'h40);
    wait_until(b + 100);
    n_cmp++;
    if (exp_rd.size() + exp_wr.size() + exp_err.size() !== 0) begin
      n_bad++;
      $display("FAIL read_drain: %0d events outstanding, required 0", exp_rd.size() + exp_wr.size() + exp_err.size());
    end
  endtask

  task automatic test_trcd();
    int b;
    do_reset();
    b = cyc;
    issue(1, 0, 0, 'h12, 0);
    wait_until(b + 38);
    push_err(b + 39, 2, 0, 0);
    issue(2, 0, 0, 0, 'h55);
    wait_until(b + 100);
    n_cmp++;
    if (exp_rd.size() + exp_wr.size() + exp_err.size() !== 0) begin
      n_bad++;
      $display("FAIL trcd_drain: %0d events outstanding, required 0", exp_rd.size() + exp_wr.size() + exp_err.size());
    end
  endtask

  task automatic test_tras_trp();
    int b;
    do_reset();
    b = cyc;
    issue(1, 0, 0, 'h3, 0);
    wait_until(b + 75);
    push_err(b + 76, 3, 0, 0);
    issue(4, 0, 0, 0, 0);
    issue(4, 0, 0, 0, 0);
    wait_until(b + 114);
    push_err(b + 115, 4, 0, 0);
    issue(1, 0, 0, 'h4, 0);
    issue(1, 0, 0, 'h4, 0);
    wait_until(b + 130);
    n_cmp++;
    if (exp_rd.size() + exp_wr.size() + exp_err.size() !== 0) begin
      n_bad++;
      $display("FAIL tras_trp_drain: %0d events outstanding, required 0", exp_rd.size() + exp_wr.size() + exp_err.size());
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_reactivated: got %b required 1", busy);
    end
  endtask

  task automatic test_twr();
    int b;
    do_reset();
    b = cyc;
    issue(1, 0, 0, 'h7, 0);
    wait_until(b + 39);
    for (int i = 0; i < 8; i++) exp_wr.push_back(b + 77 + i);
    issue(3, 0, 0, 0, 'h10);
    wait_until(b + 156);
    push_err(b + 157, 6, 0, 0);
    issue(4, 0, 0, 0, 0);
    issue(4, 0, 0, 0, 0);
    wait_until(b + 200);
    n_cmp++;
    if (exp_rd.size() + exp_wr.size() + exp_err.size() !== 0) begin
      n_bad++;
      $display("FAIL twr_drain: %0d events outstanding, required 0", exp_rd.size() + exp_wr.size() + exp_err.size());
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_after_precharge: got %b required 0", busy);
    end
  endtask

  task automatic test_ref();
    int b;
    do_reset();
    b = cyc;
    issue(1, 1, 2, 'h9, 0);
    push_err(b + 2, 1, 1, 2);
    issue(5, 1, 2, 0, 0);
    wait_until(b + 10);
    n_cmp++;
    if (exp_err.size() !== 0) begin
      n_bad++;
      $display("FAIL ref_open_drain: %0d errors outstanding, required 0", exp_err.size());
    end
    do_reset();
    b = cyc;
    issue(5, 0, 0, 0, 0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_during_ref: got %b required 1", busy);
    end
    wait_until(b + 100);
    push_err(b + 101, 9, 0, 0);
    issue(1, 0, 0, 'h1, 0);
    wait_until(b + 295);
    issue(1, 0, 0, 'h1, 0);
    wait_until(b + 334);
    push_rd(b + 374, 'h33);
    issue(2, 0, 0, 0, 'h33);
    wait_until(b + 400);
    n_cmp++;
    if (exp_rd.size() + exp_wr.size() + exp_err.size() !== 0) begin
      n_bad++;
      $display("FAIL ref_drain: %0d events outstanding, required 0", exp_rd.size() + exp_wr.size() + exp_err.size());
    end
  endtask

  task automatic test_illegal();
    int b;
    do_reset();
    b = cyc;
    push_err(b + 1, 1, 0, 0);
    issue(6, 0, 0, 0, 0);
    push_err(b + 2, 1, 3, 1);
    issue(2, 3, 1, 0, 'h5);
    push_err(b + 3, 1, 0, 0);
    issue(4, 0, 0, 0, 0);
    issue(1, 0, 0, 'h2, 0);
    push_err(b + 5, 1, 0, 0);
    issue(1, 0, 0, 'h2, 0);
    issue(0, 5, 3, 0, 0);
    push_err(b + 7, 1, 7, 3);
    issue(7, 7, 3, 0, 0);
    wait_until(b + 20);
    n_cmp++;
    if (exp_rd.size() + exp_wr.size() + exp_err.size() !== 0) begin
      n_bad++;
      $display("FAIL illegal_drain: %0d events outstanding, required 0", exp_rd.size() + exp_wr.size() + exp_err.size());
    end
  endtask

  task automatic test_slots_full();
    int b;
    do_reset();
    b = cyc;
    issue(1, 4, 3, 'h8, 0);
    for (int k = 0; k < 4; k++) begin
      wait_until(b + 40 + 8 * k);
      push_rd(b + 80 + 8 * k, 16 * k + 1);
      issue(2, 4, 3, 0, 16 * k + 1);
    end
    wait_until(b + 72);
    push_err(b + 73, 7, 4, 3);
    issue(2, 4, 3, 0, 'h7f);
    wait_until(b + 130);
    n_cmp++;
    if (exp_rd.size() + exp_wr.size() + exp_err.size() !== 0) begin
      n_bad++;
      $display("FAIL slots_drain: %0d events outstanding, required 0", exp_rd.size() + exp_wr.size() + exp_err.size());
    end
  endtask

  task automatic test_back_to_back();
    int b;
    do_reset();
    b = cyc;
    issue(1, 0, 0, 'h11, 0);
    issue(1, 2, 1, 'h22, 0);
    wait_until(b + 100);
    push_rd(b + 140, 'h100);
    issue(2, 0, 0, 0, 'h100);
    wait_until(b + 104);
    push_err(b + 105, 7, 2, 1);
    issue(2, 2, 1, 0, 'h2);
    wait_until(b + 108);
    push_rd(b + 148, 'h200);
    issue(2, 2, 1, 0, 'h200);
    wait_until(b + 145);
    while (exp_rd.size() > 0 && exp_rd[exp_rd.size() - 1].c >= b + 145) void'(exp_rd.pop_back());
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd_data_valid, wr_data_ready, err_valid, busy} !== 4'b0) begin
      n_bad++;
      $display("FAIL async_reset_flags: rd/wr/err/busy %b, required 0000", {rd_data_valid, wr_data_ready, err_valid, busy});
    end
    n_cmp++;
    if ({rd_beat, rd_col} !== '0) begin
      n_bad++;
      $display("FAIL async_reset_beat: beat %0d col 0x%0h, required 0 and 0", rd_beat, rd_col);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (exp_rd.size() + exp_wr.size() + exp_err.size() !== 0) begin
      n_bad++;
      $display("FAIL b2b_drain: %0d events outstanding, required 0", exp_rd.size() + exp_wr.size() + exp_err.size());
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_trcd();
    test_tras_trp();
    test_twr();
    test_ref();
    test_illegal();
    test_slots_full();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
